// File: rtl/rtc_alarm_timer.sv
// rtc_alarm_timer: seconds counter with a built-in prescaler, up/down counting,
// software time load and a sticky alarm flag raised on a time match.
module rtc_alarm_timer #(
  parameter int WIDTH     = 64,
  parameter int CLK_HZ    = 12000000,
  parameter int SUB_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 count_enable,
  input  logic                 load_enable,
  input  logic                 down_mode,
  input  logic [WIDTH-1:0]     i_time,
  input  logic                 alarm_we,
  input  logic [WIDTH-1:0]     i_alarm,
  input  logic                 alarm_ack,
  output logic [WIDTH-1:0]     o_time,
  output logic [SUB_WIDTH-1:0] o_sub,
  output logic                 o_tick,
  output logic                 o_alarm
);

  localparam logic [SUB_WIDTH-1:0] SUB_MAX = SUB_WIDTH'(CLK_HZ - 1);
  localparam logic [WIDTH-1:0]     ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] alarm_reg;
  logic [WIDTH-1:0] time_next;
  logic             wrap;
  logic             match;

  // Last prescaler step of a second; a load takes priority and suppresses it.
  assign wrap = count_enable && !load_enable && (o_sub == SUB_MAX);

  // Value o_time takes on this edge; down mode saturates at zero.
  always_comb begin
    time_next = o_time;
    if (load_enable)
      time_next = i_time;
    else if (wrap) begin
      if (!down_mode)
        time_next = o_time + ONE;
      else if (o_time != '0)
        time_next = o_time - ONE;
    end
  end

  // Match against the pre-write alarm value, only when o_time is refreshed.
  assign match = (load_enable || wrap) && (time_next == alarm_reg);

  // Time, prescaler and tick pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_time <= '0;
      o_sub  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_time <= time_next;
      o_tick <= wrap;
      if (load_enable || wrap)
        o_sub <= '0;
      else if (count_enable)
        o_sub <= o_sub + 1'b1;
    end
  end

  // Alarm compare register; resets to all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alarm_reg <= '1;
    else if (alarm_we)
      alarm_reg <= i_alarm;
  end

  // Sticky alarm flag; a set in the same cycle as an ack wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_alarm <= 1'b0;
    else if (match)
      o_alarm <= 1'b1;
    else if (alarm_ack)
      o_alarm <= 1'b0;
  end

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Directed bench for rtc_alarm_timer (WIDTH=8, CLK_HZ=4) plus a CLK_HZ=1 instance.
module tb_rtc_alarm_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count_enable = 1'b0;
  logic       load_enable = 1'b0;
  logic       down_mode = 1'b0;
  logic [7:0] i_time = '0;
  logic       alarm_we = 1'b0;
  logic [7:0] i_alarm = '0;
  logic       alarm_ack = 1'b0;
  logic [7:0] o_time;
  logic [1:0] o_sub;
  logic       o_tick;
  logic       o_alarm;
  logic [7:0] time1;
  logic [0:0] sub1;
  logic       tick1;
  logic       alarm1;

  int total = 0;
  int bad = 0;
  int ticks;

  rtc_alarm_timer #(.WIDTH(8), .CLK_HZ(4), .SUB_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .count_enable(count_enable), .load_enable(load_enable),
    .down_mode(down_mode), .i_time(i_time), .alarm_we(alarm_we), .i_alarm(i_alarm),
    .alarm_ack(alarm_ack), .o_time(o_time), .o_sub(o_sub), .o_tick(o_tick),
    .o_alarm(o_alarm)
  );

  rtc_alarm_timer #(.WIDTH(8), .CLK_HZ(1), .SUB_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .count_enable(count_enable), .load_enable(load_enable),
    .down_mode(down_mode), .i_time(i_time), .alarm_we(alarm_we), .i_alarm(i_alarm),
    .alarm_ack(alarm_ack), .o_time(time1), .o_sub(sub1), .o_tick(tick1),
    .o_alarm(alarm1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_time", o_time, 0);
    chk("rst_sub", o_sub, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_alarm", o_alarm, 0);
    rst = 1'b0;

    // 1: free run for 12 cycles
    count_enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("run_sub", o_sub, (i + 1) % 4);
      chk("run_tick", o_tick, ((i + 1) % 4) == 0);
      chk("hz1_tick", tick1, 1);
      chk("hz1_sub", sub1, 0);
      if (o_tick) ticks++;
    end
    chk("run_ticks", ticks, 3);
    chk("run_time", o_time, 3);
    chk("hz1_time", time1, 12);
    chk("run_alarm", o_alarm, 0);

    // 2: load FF (old alarm FF matches while 80 is written), ack, then wrap
    count_enable = 1'b0; load_enable = 1'b1; i_time = 8'hFF;
    alarm_we = 1'b1; i_alarm = 8'h80;
    step(1);
    chk("ld_time", o_time, 8'hFF);
    chk("ld_sub", o_sub, 0);
    chk("ld_tick", o_tick, 0);
    chk("we_old_cmp", o_alarm, 1);
    load_enable = 1'b0; alarm_we = 1'b0; alarm_ack = 1'b1;
    step(1);
    chk("ack_clr", o_alarm, 0);
    alarm_ack = 1'b0; count_enable = 1'b1;
    step(3);
    chk("pre_wrap_tick", o_tick, 0);
    chk("pre_wrap_time", o_time, 8'hFF);
    step(1);
    chk("wrap_time", o_time, 8'h00);
    chk("wrap_tick", o_tick, 1);
    step(1);
    chk("wrap_tick_1cyc", o_tick, 0);
    chk("wrap_no_alarm", o_alarm, 0);

    // 3: load 2, count down 4 ticks -> 1,0,0,0
    load_enable = 1'b1; i_time = 8'd2; down_mode = 1'b1;
    step(1);
    chk("dn_ld", o_time, 2);
    load_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(4);
      chk("dn_tick", o_tick, 1);
      chk("dn_time", o_time, (k == 0) ? 1 : 0);
    end

    // 4: alarm at 5, sticky, ack racing a new match
    down_mode = 1'b0; count_enable = 1'b0;
    alarm_we = 1'b1; i_alarm = 8'd5; load_enable = 1'b1; i_time = 8'd3;
    step(1);
    chk("al_ld3", o_alarm, 0);
    alarm_we = 1'b0; load_enable = 1'b0; count_enable = 1'b1;
    step(4);
    chk("al_t4_time", o_time, 4);
    chk("al_t4", o_alarm, 0);
    step(4);
    chk("al_t5_time", o_time, 5);
    chk("al_t5", o_alarm, 1);
    step(4);
    chk("al_sticky_time", o_time, 6);
    chk("al_sticky", o_alarm, 1);
    load_enable = 1'b1; i_time = 8'd5; alarm_ack = 1'b1;
    step(1);
    chk("al_set_wins", o_alarm, 1);
    load_enable = 1'b0; count_enable = 1'b0;
    step(1);
    chk("al_ack", o_alarm, 0);
    alarm_ack = 1'b0;

    // 5: load beats a tick; hold with count_enable low, then resume
    count_enable = 1'b1;
    step(3);
    chk("lt_pre_sub", o_sub, 3);
    load_enable = 1'b1; i_time = 8'd7;
    step(1);
    chk("lt_time", o_time, 7);
    chk("lt_sub", o_sub, 0);
    chk("lt_tick", o_tick, 0);
    load_enable = 1'b0;
    step(2);
    chk("hold_pre_sub", o_sub, 2);
    count_enable = 1'b0;
    step(10);
    chk("hold_sub", o_sub, 2);
    chk("hold_time", o_time, 7);
    chk("hold_tick", o_tick, 0);
    count_enable = 1'b1;
    step(1);
    chk("res_tick0", o_tick, 0);
    chk("res_sub", o_sub, 3);
    step(1);
    chk("res_tick1", o_tick, 1);
    chk("res_time", o_time, 8);

    // 6: async reset mid-count with alarm set, then reset value of alarm reg
    count_enable = 1'b0; alarm_we = 1'b1; i_alarm = 8'd7;
    step(1);
    alarm_we = 1'b0; load_enable = 1'b1; i_time = 8'd7;
    step(1);
    load_enable = 1'b0; count_enable = 1'b1;
    step(2);
    chk("pre_rst_sub", o_sub, 2);
    chk("pre_rst_time", o_time, 7);
    chk("pre_rst_alarm", o_alarm, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_time", o_time, 0);
    chk("arst_sub", o_sub, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_alarm", o_alarm, 0);
    #1 rst = 1'b0;
    count_enable = 1'b0; load_enable = 1'b1; i_time = 8'hFF;
    step(1);
    chk("rst_alarm_reg", o_alarm, 1);
    chk("rst_ld_time", o_time, 8'hFF);
    load_enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
